tx_cfg_sched: RTL and testbench
===============================

// Module: tx_cfg_sched
// PURPOSE
//  Frame-boundary scheduler for TX control configuration in the XGMII TX clock domain.
//  Takes a toggle-handshaked config request (already passed through meta_sync) and holds it in a shadow register.
//  Commits it to cfg_out only between frames, after a minimum idle gap, so no frame ever sees a mid-frame change.
//  Returns a toggle acknowledge. Flags requests deferred beyond a programmable limit.
// PARAMETERS
//  DWIDTH      8   width of config word (e.g. bit0 = tx_disable_padding)
//  GAP_CYCLES  3   consecutive idle cycles required before apply; 0 = any idle cycle
//  TMO_WIDTH   16  width of defer counter and defer_limit
// PORTS
//  clk_xgmii_tx      in   1          XGMII TX clock; the only clock
//  reset_xgmii_tx_n  in   1          asynchronous, active-low reset
//  cfg_req_tgl       in   1          request toggle (synchronized); any change = new request
//  cfg_data          in   DWIDTH     requested config; stable from toggle change until ack
//  tx_frame_active   in   1          high from SOP cycle through EOP cycle inclusive
//  defer_limit       in   TMO_WIDTH  max pending cycles before timeout flag; 0 = disabled
//  cfg_out           out  DWIDTH     applied config
//  cfg_update        out  1          1-cycle pulse, high in the first cycle a new cfg_out is visible
//  cfg_ack_tgl       out  1          equals request toggle value of last applied request
//  cfg_pending       out  1          shadow holds an unapplied request
//  defer_timeout     out  1          sticky; pending for >= defer_limit cycles
// BEHAVIOUR
//  Reset: cfg_out=0, cfg_update=0, cfg_ack_tgl=0, cfg_pending=0, defer_timeout=0, req_tgl_q=0, gap_cnt=0, state IDLE.
//  Edge detect: req_edge = cfg_req_tgl ^ req_tgl_q. On req_edge: shadow<=cfg_data, shadow_tgl<=cfg_req_tgl, req_tgl_q<=cfg_req_tgl.
//  gap_cnt counts consecutive prior cycles with tx_frame_active=0. Clears on active. Saturates at GAP_CYCLES.
//  gap_ok = !tx_frame_active && gap_cnt >= GAP_CYCLES.
//  FSM states:
//   IDLE    -> PEND on req_edge.
//   PEND    -> APPLY in a cycle where gap_ok.
//   APPLY   (1 cycle; registered outputs become visible) -> IDLE; or -> PEND if a req_edge arrived during PEND's last cycle or APPLY.
//  Apply commits: cfg_out<=shadow, cfg_ack_tgl<=shadow_tgl, cfg_update=1, cfg_pending<=0 (unless simultaneous req_edge), defer_timeout<=0.
//  Latency: edge sampled in cycle N with line idle and gap met -> cfg_out/cfg_update/ack change in cycle N+2.
//  Coalescing: req_edge while pending overwrites shadow (last wins). Only one apply occurs; ack reflects latest toggle.
//  Simultaneous apply and req_edge: apply uses the old shadow, the new request is captured, and the block stays pending.
//  tx_frame_active rising in the same cycle gap would be met: no apply (gap_ok false).
//  Defer counter: clears on entry to PEND, increments each PEND cycle, saturates at all-ones.
//   defer_timeout sets when counter == defer_limit and defer_limit != 0. It clears only on apply or reset.
//   Timeout never forces an apply mid-frame.
//  Reset mid-operation discards the shadow. The source must re-request after reset, because its toggle mismatches ack.
// CONFIGURATION
//  TX_CFG_SCHED_STATS_EN defined: adds outputs stat_applied[15:0] and stat_coalesced[15:0].
//   Both are saturating counters, reset 0.
//   stat_applied increments per apply.
//   stat_coalesced increments per req_edge while cfg_pending=1.
//  TX_CFG_SCHED_STATS_EN undefined: ports and logic are absent; all other behaviour is identical.
// STRUCTURE
//  Shared defines file: FSM state encodings (IDLE=2'd0, PEND=2'd1, APPLY=2'd2) and config bit index constants.
//  Sub-module tx_idle_gap_cnt: gap counter plus gap_ok generation, parameterized by GAP_CYCLES.
//  Top holds the edge detect, shadow register, FSM, defer counter and optional stats.
// TESTING
//  1. Idle line, GAP_CYCLES=3, toggle 0->1 with cfg_data=8'hA5 at cycle N -> cfg_out=A5, cfg_update pulse, ack=1 at N+2.
//  2. Request mid-frame (active 20 more cycles) -> no change until the 3rd idle cycle after EOP; then apply, with pending high throughout.
//  3. Two toggles (data 11 then 22) within one frame -> single apply with cfg_out=22, ack=latest toggle, stat_coalesced=1.
//  4. defer_limit=10, frame held active 50 cycles -> defer_timeout set on 10th PEND cycle, no apply until frame ends, cleared at apply.
//  5. Req_edge in APPLY cycle -> old value applied, new captured, second apply after next gap_ok.
//  6. Assert reset while PEND -> all outputs 0, no apply afterwards until a new toggle.

Source files
------------

// File: rtl/tx_cfg_sched_pkg.sv
// Shared definitions for the TX config scheduler: FSM encodings, config bit
// indices and a saturating increment helper.
package tx_cfg_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_APPLY = 2'd2
  } state_t;

  localparam int CFG_BIT_TX_DISABLE_PADDING = 0;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/tx_idle_gap_cnt.sv
// Counts consecutive idle cycles on the TX line (saturating at GAP_CYCLES)
// and flags the cycles in which a config change may be committed.
module tx_idle_gap_cnt #(
  parameter int GAP_CYCLES = 3
) (
  input  logic clk_xgmii_tx,
  input  logic reset_xgmii_tx_n,
  input  logic tx_frame_active,
  output logic gap_ok
);

  generate
    if (GAP_CYCLES == 0) begin : g_no_gap
      assign gap_ok = !tx_frame_active;
    end else begin : g_gap
      localparam int GW = $clog2(GAP_CYCLES + 1);
      logic [GW-1:0] gap_cnt;

      always_ff @(posedge clk_xgmii_tx or negedge reset_xgmii_tx_n) begin
        if (!reset_xgmii_tx_n) begin
          gap_cnt <= '0;
        end else if (tx_frame_active) begin
          gap_cnt <= '0;
        end else if (gap_cnt != GW'(GAP_CYCLES)) begin
          gap_cnt <= gap_cnt + GW'(1);
        end
      end

      // gap_cnt counts idle cycles strictly before this one, so a frame
      // starting now blocks the apply even when the count is already met.
      assign gap_ok = !tx_frame_active && (gap_cnt == GW'(GAP_CYCLES));
    end
  endgenerate

endmodule

// File: rtl/tx_cfg_sched.sv
// Frame-boundary scheduler for TX configuration: captures toggle requests into
// a shadow register and commits them only after an idle gap. Optional
// statistics counters are enabled by defining TX_CFG_SCHED_STATS_EN.
module tx_cfg_sched
  import tx_cfg_sched_pkg::*;
#(
  parameter int DWIDTH     = 8,
  parameter int GAP_CYCLES = 3,
  parameter int TMO_WIDTH  = 16
) (
  input  logic                 clk_xgmii_tx,
  input  logic                 reset_xgmii_tx_n,
  input  logic                 cfg_req_tgl,
  input  logic [DWIDTH-1:0]    cfg_data,
  input  logic                 tx_frame_active,
  input  logic [TMO_WIDTH-1:0] defer_limit,
  output logic [DWIDTH-1:0]    cfg_out,
  output logic                 cfg_update,
  output logic                 cfg_ack_tgl,
  output logic                 cfg_pending,
  output logic                 defer_timeout,
`ifdef TX_CFG_SCHED_STATS_EN
  output logic [15:0]          stat_applied,
  output logic [15:0]          stat_coalesced,
`endif
  output logic [1:0]           fsm_state
);

  state_t                state, state_nx;
  logic                  req_tgl_q;
  logic                  req_edge;
  logic [DWIDTH-1:0]     shadow;
  logic                  shadow_tgl;
  logic                  gap_ok;
  logic                  commit;
  logic [TMO_WIDTH-1:0]  defer_cnt;
  logic [TMO_WIDTH-1:0]  defer_inc;

  tx_idle_gap_cnt #(.GAP_CYCLES(GAP_CYCLES)) u_gap (
    .clk_xgmii_tx     (clk_xgmii_tx),
    .reset_xgmii_tx_n (reset_xgmii_tx_n),
    .tx_frame_active  (tx_frame_active),
    .gap_ok           (gap_ok)
  );

  assign req_edge  = cfg_req_tgl ^ req_tgl_q;
  assign commit    = (state == ST_PEND) && gap_ok;
  assign defer_inc = (&defer_cnt) ? defer_cnt : defer_cnt + TMO_WIDTH'(1);
  assign fsm_state = state;

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (req_edge) state_nx = ST_PEND;
      ST_PEND:  if (gap_ok) state_nx = ST_APPLY;
      // cfg_pending here means an edge landed in the committing cycle.
      ST_APPLY: state_nx = (cfg_pending || req_edge) ? ST_PEND : ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_xgmii_tx or negedge reset_xgmii_tx_n) begin
    if (!reset_xgmii_tx_n) begin
      state      <= ST_IDLE;
      req_tgl_q  <= 1'b0;
      shadow     <= '0;
      shadow_tgl <= 1'b0;
      defer_cnt  <= '0;
    end else begin
      state     <= state_nx;
      req_tgl_q <= cfg_req_tgl;
      if (req_edge) begin
        shadow     <= cfg_data;
        shadow_tgl <= cfg_req_tgl;
      end
      if (state_nx == ST_PEND && state != ST_PEND) begin
        defer_cnt <= '0;
      end else if (state == ST_PEND) begin
        defer_cnt <= defer_inc;
      end
    end
  end

  // The commit reads the shadow before this cycle's capture, so a simultaneous
  // request is kept for the next apply.
  always_ff @(posedge clk_xgmii_tx or negedge reset_xgmii_tx_n) begin
    if (!reset_xgmii_tx_n) begin
      cfg_out       <= '0;
      cfg_update    <= 1'b0;
      cfg_ack_tgl   <= 1'b0;
      cfg_pending   <= 1'b0;
      defer_timeout <= 1'b0;
    end else begin
      cfg_update <= commit;
      if (commit) begin
        cfg_out       <= shadow;
        cfg_ack_tgl   <= shadow_tgl;
        defer_timeout <= 1'b0;
      end else if (state == ST_PEND && defer_limit != '0 && defer_inc == defer_limit) begin
        defer_timeout <= 1'b1;
      end
      if (req_edge) begin
        cfg_pending <= 1'b1;
      end else if (commit) begin
        cfg_pending <= 1'b0;
      end
    end
  end

`ifdef TX_CFG_SCHED_STATS_EN
  always_ff @(posedge clk_xgmii_tx or negedge reset_xgmii_tx_n) begin
    if (!reset_xgmii_tx_n) begin
      stat_applied   <= '0;
      stat_coalesced <= '0;
    end else begin
      if (commit) stat_applied <= sat_inc16(stat_applied);
      if (req_edge && cfg_pending) stat_coalesced <= sat_inc16(stat_coalesced);
    end
  end
`endif

endmodule

// File: tb/tb_tx_cfg_sched.sv
// Directed bench for tx_cfg_sched: one task per scenario, inline comparisons,
// inputs driven and outputs sampled 1 ns after each rising edge.
module tb_tx_cfg_sched;

  logic        clk_xgmii_tx = 1'b0;
  logic        reset_xgmii_tx_n;
  logic        cfg_req_tgl;
  logic [7:0]  cfg_data;
  logic        tx_frame_active;
  logic [15:0] defer_limit;
  logic [7:0]  cfg_out;
  logic        cfg_update;
  logic        cfg_ack_tgl;
  logic        cfg_pending;
  logic        defer_timeout;
  logic [1:0]  fsm_state;
`ifdef TX_CFG_SCHED_STATS_EN
  logic [15:0] stat_applied;
  logic [15:0] stat_coalesced;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk_xgmii_tx = ~clk_xgmii_tx;

  tx_cfg_sched dut (
    .clk_xgmii_tx     (clk_xgmii_tx),
    .reset_xgmii_tx_n (reset_xgmii_tx_n),
    .cfg_req_tgl      (cfg_req_tgl),
    .cfg_data         (cfg_data),
    .tx_frame_active  (tx_frame_active),
    .defer_limit      (defer_limit),
    .cfg_out          (cfg_out),
    .cfg_update       (cfg_update),
    .cfg_ack_tgl      (cfg_ack_tgl),
    .cfg_pending      (cfg_pending),
    .defer_timeout    (defer_timeout),
`ifdef TX_CFG_SCHED_STATS_EN
    .stat_applied     (stat_applied),
    .stat_coalesced   (stat_coalesced),
`endif
    .fsm_state        (fsm_state)
  );

  task automatic step();
    @(posedge clk_xgmii_tx);
    #1;
  endtask

  task automatic test_reset();
    reset_xgmii_tx_n = 1'b0;
    cfg_req_tgl = 1'b0;
    cfg_data = 8'h00;
    tx_frame_active = 1'b0;
    defer_limit = 16'd0;
    repeat (3) step();
    checks++;
    if ({cfg_out, cfg_update, cfg_ack_tgl, cfg_pending, defer_timeout, fsm_state} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs got out=%h upd=%b ack=%b pend=%b tmo=%b st=%0d exp all 0",
               cfg_out, cfg_update, cfg_ack_tgl, cfg_pending, defer_timeout, fsm_state);
    end
`ifdef TX_CFG_SCHED_STATS_EN
    checks++;
    if (stat_applied !== 16'd0 || stat_coalesced !== 16'd0) begin
      errors++;
      $display("FAIL reset_stats got %0d/%0d exp 0/0", stat_applied, stat_coalesced);
    end
`endif
    reset_xgmii_tx_n = 1'b1;
    repeat (5) step();
  endtask

  // Idle line with gap met: request in cycle N appears in N+2.
  task automatic test_idle_apply();
    cfg_req_tgl = 1'b1;
    cfg_data = 8'hA5;
    step();
    checks++;
    if (cfg_out !== 8'h00 || cfg_update !== 1'b0 || cfg_pending !== 1'b1) begin
      errors++;
      $display("FAIL idle_n1 got out=%h upd=%b pend=%b exp 00/0/1", cfg_out, cfg_update, cfg_pending);
    end
    step();
    checks++;
    if (cfg_out !== 8'hA5 || cfg_update !== 1'b1 || cfg_ack_tgl !== 1'b1 || cfg_pending !== 1'b0) begin
      errors++;
      $display("FAIL idle_n2 got out=%h upd=%b ack=%b pend=%b exp a5/1/1/0",
               cfg_out, cfg_update, cfg_ack_tgl, cfg_pending);
    end
    step();
    checks++;
    if (cfg_update !== 1'b0 || fsm_state !== 2'd0) begin
      errors++;
      $display("FAIL idle_n3 got upd=%b st=%0d exp 0/0", cfg_update, fsm_state);
    end
  endtask

  // Request mid-frame waits for the idle gap after EOP.
  task automatic test_mid_frame();
    tx_frame_active = 1'b1;
    step();
    cfg_req_tgl = 1'b0;
    cfg_data = 8'h3C;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (cfg_out !== 8'hA5 || cfg_pending !== 1'b1 || cfg_update !== 1'b0) begin
        errors++;
        $display("FAIL mid_frame_hold[%0d] got out=%h pend=%b upd=%b exp a5/1/0",
                 i, cfg_out, cfg_pending, cfg_update);
      end
    end
    step();
    tx_frame_active = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (cfg_out !== 8'hA5 || cfg_pending !== 1'b1 || cfg_update !== 1'b0) begin
        errors++;
        $display("FAIL mid_frame_gap[%0d] got out=%h pend=%b upd=%b exp a5/1/0",
                 i, cfg_out, cfg_pending, cfg_update);
      end
      step();
    end
    checks++;
    if (cfg_out !== 8'h3C || cfg_update !== 1'b1 || cfg_ack_tgl !== 1'b0 || cfg_pending !== 1'b0) begin
      errors++;
      $display("FAIL mid_frame_apply got out=%h upd=%b ack=%b pend=%b exp 3c/1/0/0",
               cfg_out, cfg_update, cfg_ack_tgl, cfg_pending);
    end
  endtask

  task automatic test_coalesce();
    int n_upd;
    n_upd = 0;
    tx_frame_active = 1'b1;
    step();
    cfg_req_tgl = 1'b1;
    cfg_data = 8'h11;
    step();
    step();
    cfg_req_tgl = 1'b0;
    cfg_data = 8'h22;
    repeat (3) begin
      step();
      checks++;
      if (cfg_pending !== 1'b1 || cfg_update !== 1'b0) begin
        errors++;
        $display("FAIL coalesce_hold got pend=%b upd=%b exp 1/0", cfg_pending, cfg_update);
      end
    end
    step();
    tx_frame_active = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (cfg_update === 1'b1) begin
        n_upd++;
        checks++;
        if (cfg_out !== 8'h22 || cfg_ack_tgl !== 1'b0) begin
          errors++;
          $display("FAIL coalesce_value got out=%h ack=%b exp 22/0", cfg_out, cfg_ack_tgl);
        end
      end
    end
    checks++;
    if (n_upd !== 1 || cfg_pending !== 1'b0) begin
      errors++;
      $display("FAIL coalesce_count got updates=%0d pend=%b exp 1/0", n_upd, cfg_pending);
    end
`ifdef TX_CFG_SCHED_STATS_EN
    checks++;
    if (stat_coalesced !== 16'd1 || stat_applied !== 16'd3) begin
      errors++;
      $display("FAIL coalesce_stats got coal=%0d appl=%0d exp 1/3", stat_coalesced, stat_applied);
    end
`endif
  endtask

  // Timeout sets after 10 PEND cycles (visible from the 11th) and clears at apply.
  task automatic test_timeout();
    logic got;
    got = 1'b0;
    defer_limit = 16'd10;
    tx_frame_active = 1'b1;
    cfg_req_tgl = 1'b1;
    cfg_data = 8'h77;
    for (int i = 1; i < 50; i++) begin
      step();
      if (i == 10) begin
        checks++;
        if (defer_timeout !== 1'b0 || fsm_state !== 2'd1) begin
          errors++;
          $display("FAIL timeout_early got tmo=%b st=%0d exp 0/1", defer_timeout, fsm_state);
        end
      end
      if (i == 11 || i == 49) begin
        checks++;
        if (defer_timeout !== 1'b1) begin
          errors++;
          $display("FAIL timeout_set[%0d] got %b exp 1", i, defer_timeout);
        end
      end
      if (cfg_update !== 1'b0 || cfg_out !== 8'h22) begin
        checks++;
        errors++;
        $display("FAIL timeout_no_apply[%0d] got upd=%b out=%h exp 0/22", i, cfg_update, cfg_out);
      end
    end
    step();
    tx_frame_active = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      if (cfg_update === 1'b1) begin
        got = 1'b1;
        checks++;
        if (cfg_out !== 8'h77 || cfg_ack_tgl !== 1'b1 || defer_timeout !== 1'b0) begin
          errors++;
          $display("FAIL timeout_apply got out=%h ack=%b tmo=%b exp 77/1/0",
                   cfg_out, cfg_ack_tgl, defer_timeout);
        end
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL timeout_wait got no update exp update within 10 cycles");
    end
    defer_limit = 16'd0;
  endtask

  // Edge in the APPLY cycle, then an edge in the committing PEND cycle.
  task automatic test_back_to_back();
    cfg_req_tgl = 1'b0;
    cfg_data = 8'h5A;
    step();
    step();
    checks++;
    if (cfg_out !== 8'h5A || cfg_update !== 1'b1 || cfg_ack_tgl !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first got out=%h upd=%b ack=%b exp 5a/1/0", cfg_out, cfg_update, cfg_ack_tgl);
    end
    cfg_req_tgl = 1'b1;
    cfg_data = 8'hC3;
    step();
    checks++;
    if (cfg_out !== 8'h5A || cfg_update !== 1'b0 || cfg_pending !== 1'b1 || fsm_state !== 2'd1) begin
      errors++;
      $display("FAIL b2b_hold got out=%h upd=%b pend=%b st=%0d exp 5a/0/1/1",
               cfg_out, cfg_update, cfg_pending, fsm_state);
    end
    step();
    checks++;
    if (cfg_out !== 8'hC3 || cfg_update !== 1'b1 || cfg_ack_tgl !== 1'b1 || cfg_pending !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second got out=%h upd=%b ack=%b pend=%b exp c3/1/1/0",
               cfg_out, cfg_update, cfg_ack_tgl, cfg_pending);
    end
    repeat (2) step();
    cfg_req_tgl = 1'b0;
    cfg_data = 8'h0F;
    step();
    cfg_req_tgl = 1'b1;
    cfg_data = 8'hF0;
    step();
    checks++;
    if (cfg_out !== 8'h0F || cfg_update !== 1'b1 || cfg_ack_tgl !== 1'b0 || cfg_pending !== 1'b1) begin
      errors++;
      $display("FAIL simul_old got out=%h upd=%b ack=%b pend=%b exp 0f/1/0/1",
               cfg_out, cfg_update, cfg_ack_tgl, cfg_pending);
    end
    step();
    step();
    checks++;
    if (cfg_out !== 8'hF0 || cfg_update !== 1'b1 || cfg_ack_tgl !== 1'b1 || cfg_pending !== 1'b0) begin
      errors++;
      $display("FAIL simul_new got out=%h upd=%b ack=%b pend=%b exp f0/1/1/0",
               cfg_out, cfg_update, cfg_ack_tgl, cfg_pending);
    end
  endtask

  task automatic test_reset_pending();
    logic bad;
    bad = 1'b0;
    tx_frame_active = 1'b1;
    step();
    cfg_req_tgl = 1'b0;
    cfg_data = 8'h99;
    step();
    checks++;
    if (cfg_pending !== 1'b1) begin
      errors++;
      $display("FAIL rstpend_pending got %b exp 1", cfg_pending);
    end
    #2;
    reset_xgmii_tx_n = 1'b0;
    #1;
    checks++;
    if ({cfg_out, cfg_update, cfg_ack_tgl, cfg_pending, defer_timeout, fsm_state} !== 14'd0) begin
      errors++;
      $display("FAIL rstpend_async got out=%h upd=%b ack=%b pend=%b tmo=%b st=%0d exp all 0",
               cfg_out, cfg_update, cfg_ack_tgl, cfg_pending, defer_timeout, fsm_state);
    end
    step();
    reset_xgmii_tx_n = 1'b1;
    tx_frame_active = 1'b0;
    repeat (10) begin
      step();
      if (cfg_update !== 1'b0 || cfg_pending !== 1'b0 || cfg_out !== 8'h00) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL rstpend_no_apply got spurious activity out=%h pend=%b exp 00/0", cfg_out, cfg_pending);
    end
    cfg_req_tgl = 1'b1;
    cfg_data = 8'h42;
    step();
    step();
    checks++;
    if (cfg_out !== 8'h42 || cfg_update !== 1'b1 || cfg_ack_tgl !== 1'b1) begin
      errors++;
      $display("FAIL rstpend_rerequest got out=%h upd=%b ack=%b exp 42/1/1", cfg_out, cfg_update, cfg_ack_tgl);
    end
`ifdef TX_CFG_SCHED_STATS_EN
    checks++;
    if (stat_applied !== 16'd1 || stat_coalesced !== 16'd0) begin
      errors++;
      $display("FAIL rstpend_stats got appl=%0d coal=%0d exp 1/0", stat_applied, stat_coalesced);
    end
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_idle_apply();
    test_mid_frame();
    test_coalesce();
    test_timeout();
    test_back_to_back();
    test_reset_pending();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
